// File: rtl/sam_stream_source_if.sv
// Stream link from the frame source to the SAM input path.
// A beat moves on any rising edge where out_valid && out_ready are both high.
interface sam_stream_source_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/sam_stream_source.sv
// Arithmetic-sequence AXI-Stream frame generator for bring-up and loopback runs.
// Emits num_frames frames of frame_len words (seed + k*step), with optional idle gaps, then pulses done.
module sam_stream_source #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16,
    parameter int GAP_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [LEN_W-1:0]    frame_len_i,
    input  logic [LEN_W-1:0]    num_frames_i,
    input  logic [DATA_W-1:0]   seed_i,
    input  logic [DATA_W-1:0]   step_i,
    input  logic [GAP_W-1:0]    gap_i,
    sam_stream_source_if.master out_if,
    output logic                busy_o,
    output logic                done_o,
    output logic [LEN_W-1:0]    frames_sent_o,
    output logic [1:0]          state_o
);
    // Stream handshake: out_valid/out_data/out_last are registered and held until the
    // cycle where out_ready is also high; out_valid never depends on out_ready.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   frames_q;
    logic [DATA_W-1:0]  step_q;
    logic [GAP_W-1:0]   gap_q;
    logic [DATA_W-1:0]  data_q;
    logic [LEN_W-1:0]   beat_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic [LEN_W-1:0]   frames_sent_q;
    logic               valid_q;
    logic               last_q;
    logic               busy_q;
    logic               done_q;

    logic [DATA_W-1:0]  data_d;
    logic [LEN_W-1:0]   beat_d;
    logic [LEN_W-1:0]   frames_sent_d;
    logic               single_d;

    always_comb begin
        data_d        = data_q + step_q;
        beat_d        = beat_q + LEN_W'(1);
        frames_sent_d = frames_sent_q + LEN_W'(1);
        single_d      = (len_q == LEN_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            len_q         <= '0;
            frames_q      <= '0;
            step_q        <= '0;
            gap_q         <= '0;
            data_q        <= '0;
            beat_q        <= '0;
            gap_cnt_q     <= '0;
            frames_sent_q <= '0;
            valid_q       <= 1'b0;
            last_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        frames_sent_q <= '0;
                        if (frame_len_i != '0 && num_frames_i != '0) begin
                            len_q    <= frame_len_i;
                            frames_q <= num_frames_i;
                            step_q   <= step_i;
                            gap_q    <= gap_i;
                            data_q   <= seed_i;
                            beat_q   <= '0;
                            valid_q  <= 1'b1;
                            last_q   <= (frame_len_i == LEN_W'(1));
                            busy_q   <= 1'b1;
                            state_q  <= SEND;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (valid_q && out_if.out_ready) begin
                        // Word index runs across frames, so data simply keeps stepping.
                        data_q <= data_d;
                        if (last_q) begin
                            frames_sent_q <= frames_sent_d;
                            beat_q        <= '0;
                            if (frames_sent_d == frames_q) begin
                                valid_q <= 1'b0;
                                last_q  <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end else if (gap_q == '0) begin
                                last_q <= single_d;
                            end else begin
                                valid_q   <= 1'b0;
                                last_q    <= 1'b0;
                                gap_cnt_q <= gap_q;
                                state_q   <= GAP;
                            end
                        end else begin
                            beat_q <= beat_d;
                            last_q <= (beat_d == len_q - LEN_W'(1));
                        end
                    end
                end
                GAP: begin
                    // Valid rises on the cycle after the counter's final idle cycle.
                    gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    if (gap_cnt_q == GAP_W'(1)) begin
                        valid_q <= 1'b1;
                        last_q  <= single_d;
                        state_q <= SEND;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_if.out_data  = data_q;
    assign out_if.out_valid = valid_q;
    assign out_if.out_last  = last_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign frames_sent_o    = frames_sent_q;
    assign state_o          = state_q;
endmodule

// File: tb/tb_sam_stream_source.sv
// Bench for sam_stream_source: queue scoreboard fed by a sequence model, negedge monitor.
`timescale 1ns/1ps
module tb_sam_stream_source;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;
    localparam int GAP_W  = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              start = 1'b0;
    logic [LEN_W-1:0]  frame_len = '0;
    logic [LEN_W-1:0]  num_frames = '0;
    logic [DATA_W-1:0] seed = '0;
    logic [DATA_W-1:0] step = '0;
    logic [GAP_W-1:0]  gap = '0;
    logic              ready = 1'b0;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  frames_sent;
    logic [1:0]        state_dbg;

    sam_stream_source_if #(.DATA_W(DATA_W)) s_if ();
    assign s_if.out_ready = ready;

    sam_stream_source #(.DATA_W(DATA_W), .LEN_W(LEN_W), .GAP_W(GAP_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .frame_len_i  (frame_len),
        .num_frames_i (num_frames),
        .seed_i       (seed),
        .step_i       (step),
        .gap_i        (gap),
        .out_if       (s_if.master),
        .busy_o       (busy),
        .done_o       (done),
        .frames_sent_o(frames_sent),
        .state_o      (state_dbg)
    );

    int checks = 0;
    int errors = 0;
    logic [DATA_W:0] exp_q[$];
    int m_gap = 0;
    int ready_mode = 0;  // 0 always high, 1 random, 2 manual, 3 fixed pattern
    int pat_idx = 0;
    bit pat[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) ready = 1'b1;
        else if (ready_mode == 1) ready = 1'($urandom_range(0, 1));
        else if (ready_mode == 3) begin
            ready = pat[pat_idx % 8];
            pat_idx++;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [DATA_W:0]   e;
        bit                prev_hold;
        logic [DATA_W-1:0] prev_data;
        logic              prev_last;
        bit                after_last;
        int                gcount;
        prev_hold = 0; after_last = 0; gcount = 0; prev_data = '0; prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold  = 0;
                after_last = 0;
            end else begin
                if (prev_hold)
                    check(s_if.out_valid && s_if.out_data == prev_data && s_if.out_last == prev_last,
                          "hold_stable", {31'b0, s_if.out_last, s_if.out_data}, {31'b0, prev_last, prev_data});
                prev_hold = s_if.out_valid && !ready;
                prev_data = s_if.out_data;
                prev_last = s_if.out_last;
                if (done) after_last = 0;
                else if (after_last) begin
                    if (s_if.out_valid) begin
                        check(gcount == m_gap, "gap_cycles", 64'(gcount), 64'(m_gap));
                        after_last = 0;
                    end else gcount++;
                end
                if (s_if.out_valid && ready) begin
                    if (exp_q.size() == 0)
                        check(1'b0, "unexpected_beat", 64'(s_if.out_data), 64'(0));
                    else begin
                        e = exp_q.pop_front();
                        check({s_if.out_last, s_if.out_data} == e, "beat",
                              {31'b0, s_if.out_last, s_if.out_data}, {31'b0, e});
                    end
                    if (s_if.out_last) begin
                        after_last = 1;
                        gcount = 0;
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Reference: word k of a run is seed + k*step; last when k mod len == len-1.
    task automatic run_cfg(input int len, input int nf, input logic [DATA_W-1:0] sd,
                           input logic [DATA_W-1:0] st, input int gp, input int poke);
        bit degen;
        int exp_lat;
        int n;
        bit got_done;
        degen = (len == 0) || (nf == 0);
        m_gap = gp;
        exp_lat = degen ? 1 : len * nf + gp * (nf - 1) + 1;
        if (!degen)
            for (int k = 0; k < len * nf; k++)
                exp_q.push_back({((k % len) == len - 1), sd + st * DATA_W'(k)});
        @(posedge clk); #1;
        frame_len = LEN_W'(len); num_frames = LEN_W'(nf);
        seed = sd; step = st; gap = GAP_W'(gp);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        got_done = 0;
        while (n <= 4000) begin
            @(negedge clk);
            if (n == 1 && ready_mode == 0 && !degen)
                check(s_if.out_valid && s_if.out_data == sd, "first_beat_latency",
                      {31'b0, s_if.out_valid, s_if.out_data}, {32'b1, sd});
            if (done) begin
                got_done = 1;
                break;
            end
            check(busy == !degen, "busy_during_run", 64'(busy), 64'(!degen));
            if (degen) check(!s_if.out_valid, "degen_no_valid", 64'(s_if.out_valid), 64'(0));
            @(posedge clk); #1;
            if (n + 1 == poke) begin
                start = 1'b1;
                seed  = sd ^ 32'h5A5A_0F0F;
                frame_len = LEN_W'(len + 1);
            end else start = 1'b0;
            n++;
        end
        check(got_done, "done_timeout", 64'(n), 64'(exp_lat));
        if (got_done) begin
            if (ready_mode == 0) check(n == exp_lat, "done_latency", 64'(n), 64'(exp_lat));
            check(!busy, "busy_at_done", 64'(busy), 64'(0));
            check(!s_if.out_valid, "valid_at_done", 64'(s_if.out_valid), 64'(0));
            check(frames_sent == LEN_W'(degen ? 0 : nf), "frames_sent", 64'(frames_sent), 64'(degen ? 0 : nf));
            check(exp_q.size() == 0, "missing_beats", 64'(exp_q.size()), 64'(0));
            @(negedge clk);
            check(!done, "done_one_cycle", 64'(done), 64'(0));
        end
        exp_q.delete();
        start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        repeat (3) @(posedge clk);
        @(negedge clk);
        check(!s_if.out_valid && !s_if.out_last && s_if.out_data == '0 && !busy && !done && frames_sent == '0,
              "reset_state", {s_if.out_valid, s_if.out_last, busy, done, frames_sent, s_if.out_data}, 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        ready_mode = 0;
        run_cfg(4, 1, 32'h10, 32'h1, 0, 0);
        ready_mode = 3; pat_idx = 0;
        run_cfg(4, 1, 32'h10, 32'h1, 0, 0);
        ready_mode = 0;
        run_cfg(2, 3, 32'h0, 32'h2, 3, 0);
        run_cfg(2, 2, 32'hFFFF_FFFE, 32'h1, 0, 0);
        run_cfg(0, 3, 32'h55, 32'h1, 0, 0);
        run_cfg(3, 0, 32'h55, 32'h1, 0, 0);
        run_cfg(4, 2, 32'h100, 32'h7, 1, 3);
        run_cfg(1, 4, 32'h20, 32'hFFFF_FFFF, 0, 0);
        run_cfg(1, 3, 32'h30, 32'h3, 2, 0);

        // Abort mid-run: second frame, beat 2 held by backpressure.
        ready_mode = 2; ready = 1'b1;
        for (int k = 0; k < 8; k++) exp_q.push_back({((k % 4) == 3), 32'hA0 + 32'h3 * DATA_W'(k)});
        m_gap = 0;
        frame_len = 4; num_frames = 2; seed = 32'hA0; step = 32'h3; gap = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        ready = 1'b0;
        @(negedge clk);
        check(frames_sent == LEN_W'(1) && s_if.out_valid, "pre_reset_progress",
              {31'b0, s_if.out_valid, 16'b0, frames_sent}, {32'b1, 32'h1});
        check(exp_q.size() == 3, "pre_reset_beats", 64'(exp_q.size()), 64'(3));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check(!s_if.out_valid && !busy && frames_sent == '0 && !s_if.out_last && s_if.out_data == '0 && !done,
              "after_reset", {s_if.out_valid, busy, s_if.out_last, done, frames_sent, s_if.out_data}, 64'(0));
        exp_q.delete();
        ready_mode = 0;
        run_cfg(4, 1, 32'hA0, 32'h3, 0, 0);

        for (int r = 0; r < 12; r++) begin
            ready_mode = int'($urandom_range(0, 1));
            run_cfg(int'($urandom_range(1, 5)), int'($urandom_range(1, 3)), $urandom, $urandom,
                    int'($urandom_range(0, 3)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
